e_m_pipe_reg: RTL and testbench

//   EX->MEM pipeline register that feeds the data memory stage. Captures the ALU

---
 rtl/e_m_pipe_reg.sv | 156 +++++++++++++++
 tb/tb_e_m_pipe_reg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/e_m_pipe_reg.sv
// ---------------------------------------------------------------------------
// e_m_pipe_reg
//   EX->MEM pipeline register in front of the data memory stage.
//   Captures the effective address, store data, PC, instruction word, DM
//   control and writeback tags produced in E. It supports stall (hold) and
//   flush (bubble), ages the hazard Tnew counter, and checks every memory
//   access for alignment and range faults. A faulting access has its side
//   effects stripped before it reaches DM: a store loses its write enable,
//   and a load loses its register write.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   stall               hold all M-side state (Tnew still ages)
//   flush               load a bubble
//   E_PC, E_Instr       PC and instruction word of the instruction in E
//   E_ALUout            effective address / ALU result
//   E_WD                store data (forwarded rt)
//   E_DM_op             access size code (w/h/hu/b/bu)
//   E_DM_wr, E_DM_rd    store / load flags
//   E_RegWrite, E_A3    GPR write enable and destination
//   E_Tnew              cycles until the result is ready, measured at E
//   M_*                 registered copies for the MEM stage
//   M_valid             1 = real instruction, 0 = bubble
//   M_adel, M_ades      load / store address fault for this instruction
// ---------------------------------------------------------------------------
module e_m_pipe_reg #(
  parameter int DM_ADDR_BITS = 12,
  parameter int TNEW_W       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       E_PC,
  input  logic [31:0]       E_Instr,
  input  logic [31:0]       E_ALUout,
  input  logic [31:0]       E_WD,
  input  logic [2:0]        E_DM_op,
  input  logic              E_DM_wr,
  input  logic              E_DM_rd,
  input  logic              E_RegWrite,
  input  logic [4:0]        E_A3,
  input  logic [TNEW_W-1:0] E_Tnew,
  output logic [31:0]       M_A,
  output logic [31:0]       M_WD,
  output logic [31:0]       M_PC,
  output logic [31:0]       M_Instr,
  output logic [2:0]        M_DM_op,
  output logic              M_DM_wr,
  output logic              M_DM_rd,
  output logic              M_RegWrite,
  output logic [4:0]        M_A3,
  output logic [TNEW_W-1:0] M_Tnew,
  output logic              M_valid,
  output logic              M_adel,
  output logic              M_ades
);

  // Access size codes shared with the DM stage.
  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  // Decrement that stops at zero.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    if (x == '0) sat_dec = '0;
    else         sat_dec = x - TNEW_W'(1);
  endfunction

  // Alignment check by access size; unknown size codes count as misaligned
  // so that a garbled op can never slip a write into DM.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      DM_W:         misaligned = (a != 2'b00);
      DM_H, DM_HU:  misaligned = a[0];
      DM_B, DM_BU:  misaligned = 1'b0;
      default:      misaligned = 1'b1;
    endcase
  endfunction

  // ---- E stage: fault check and next-state decode -------------------------
  logic              is_store_p0;
  logic              is_load_p0;
  logic              mis_p0;
  logic              oor_p0;
  logic              bad_p0;
  logic              ades_p0;
  logic              adel_p0;
  logic              dm_wr_p0;
  logic              dm_rd_p0;
  logic              reg_write_p0;
  logic [4:0]        a3_p0;
  logic [TNEW_W-1:0] tnew_p0;

  always_comb begin
    // A simultaneous load+store request is illegal and is handled as a store.
    is_store_p0  = E_DM_wr;
    is_load_p0   = E_DM_rd & ~E_DM_wr;
    mis_p0       = misaligned(E_DM_op, E_ALUout[1:0]);
    oor_p0       = (E_ALUout[31:DM_ADDR_BITS] != '0);
    bad_p0       = (is_store_p0 | is_load_p0) & (mis_p0 | oor_p0);

    ades_p0      = is_store_p0 & bad_p0;
    adel_p0      = is_load_p0 & bad_p0;

    dm_wr_p0     = is_store_p0 & ~bad_p0;
    dm_rd_p0     = is_load_p0;

    // Writes to $0 are dropped; a faulting load never writes back.
    reg_write_p0 = E_RegWrite & (E_A3 != 5'd0) & ~adel_p0;
    a3_p0        = reg_write_p0 ? E_A3 : 5'd0;

    tnew_p0      = adel_p0 ? '0 : sat_dec(E_Tnew);
  end

  // ---- E -> M register ----------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      M_A        <= '0;
      M_WD       <= '0;
      M_PC       <= '0;
      M_Instr    <= '0;
      M_DM_op    <= '0;
      M_DM_wr    <= 1'b0;
      M_DM_rd    <= 1'b0;
      M_RegWrite <= 1'b0;
      M_A3       <= '0;
      M_Tnew     <= '0;
      M_valid    <= 1'b0;
      M_adel     <= 1'b0;
      M_ades     <= 1'b0;
    end else if (stall) begin
      // Everything holds, but the result keeps getting closer to ready.
      M_Tnew     <= sat_dec(M_Tnew);
    end else begin
      // Address and data are captured even on a fault so exception handling
      // can report the offending PC and address.
      M_A        <= E_ALUout;
      M_WD       <= E_WD;
      M_PC       <= E_PC;
      M_Instr    <= E_Instr;
      M_DM_op    <= E_DM_op;
      M_DM_wr    <= dm_wr_p0;
      M_DM_rd    <= dm_rd_p0;
      M_RegWrite <= reg_write_p0;
      M_A3       <= a3_p0;
      M_Tnew     <= tnew_p0;
      M_valid    <= 1'b1;
      M_adel     <= adel_p0;
      M_ades     <= ades_p0;
    end
  end

endmodule

// File: tb/tb_e_m_pipe_reg.sv
module tb_e_m_pipe_reg;

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_B  = 3'd3;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] E_PC, E_Instr, E_ALUout, E_WD;
  logic [2:0]  E_DM_op;
  logic        E_DM_wr, E_DM_rd, E_RegWrite;
  logic [4:0]  E_A3;
  logic [1:0]  E_Tnew;
  logic [31:0] M_A, M_WD, M_PC, M_Instr;
  logic [2:0]  M_DM_op;
  logic        M_DM_wr, M_DM_rd, M_RegWrite;
  logic [4:0]  M_A3;
  logic [1:0]  M_Tnew;
  logic        M_valid, M_adel, M_ades;

  int vecs = 0;
  int errs = 0;

  e_m_pipe_reg #(.DM_ADDR_BITS(12), .TNEW_W(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .E_PC(E_PC), .E_Instr(E_Instr), .E_ALUout(E_ALUout), .E_WD(E_WD),
    .E_DM_op(E_DM_op), .E_DM_wr(E_DM_wr), .E_DM_rd(E_DM_rd),
    .E_RegWrite(E_RegWrite), .E_A3(E_A3), .E_Tnew(E_Tnew),
    .M_A(M_A), .M_WD(M_WD), .M_PC(M_PC), .M_Instr(M_Instr),
    .M_DM_op(M_DM_op), .M_DM_wr(M_DM_wr), .M_DM_rd(M_DM_rd),
    .M_RegWrite(M_RegWrite), .M_A3(M_A3), .M_Tnew(M_Tnew),
    .M_valid(M_valid), .M_adel(M_adel), .M_ades(M_ades)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] op, input logic wr, input logic rd,
                       input logic rw, input logic [4:0] a3, input logic [1:0] tn);
    E_PC = pc; E_Instr = instr; E_ALUout = a; E_WD = wd; E_DM_op = op;
    E_DM_wr = wr; E_DM_rd = rd; E_RegWrite = rw; E_A3 = a3; E_Tnew = tn;
  endtask

  initial begin
    // 1: reset beats stall, valid E inputs present
    reset = 1'b1; stall = 1'b1; flush = 1'b0;
    set_e(32'h3000, 32'hAC09_0104, 32'h104, 32'hDEAD_BEEF, DM_W, 1'b1, 1'b0, 1'b1, 5'd9, 2'd2);
    tick();
    chk("rst_A", M_A, 32'h0);
    chk("rst_WD", M_WD, 32'h0);
    chk("rst_PC", M_PC, 32'h0);
    chk("rst_Instr", M_Instr, 32'h0);
    chk("rst_ctl", {M_DM_op, M_DM_wr, M_DM_rd, M_RegWrite, M_A3, M_Tnew}, 32'h0);
    chk("rst_valid", {M_valid, M_adel, M_ades}, 32'h0);

    // 2: aligned in-range sw
    reset = 1'b0; stall = 1'b0;
    set_e(32'h3000, 32'hAC09_0104, 32'h104, 32'hDEAD_BEEF, DM_W, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    tick();
    chk("sw_DM_wr", M_DM_wr, 1);
    chk("sw_A", M_A, 32'h104);
    chk("sw_WD", M_WD, 32'hDEAD_BEEF);
    chk("sw_PC", M_PC, 32'h3000);
    chk("sw_ades", M_ades, 0);
    chk("sw_valid", M_valid, 1);

    // 3a: misaligned sh
    set_e(32'h3004, 32'hA409_0103, 32'h103, 32'h1234, DM_H, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    tick();
    chk("sh_ades", M_ades, 1);
    chk("sh_DM_wr", M_DM_wr, 0);
    chk("sh_A_kept", M_A, 32'h103);

    // 3b: out-of-range lw
    set_e(32'h3008, 32'h8C08_2000, 32'h2000, 32'h0, DM_W, 1'b0, 1'b1, 1'b1, 5'd8, 2'd2);
    tick();
    chk("lw_oor_adel", M_adel, 1);
    chk("lw_oor_ades", M_ades, 0);
    chk("lw_oor_rw", M_RegWrite, 0);
    chk("lw_oor_A3", M_A3, 0);
    chk("lw_oor_Tnew", M_Tnew, 0);
    chk("lw_oor_PC", M_PC, 32'h3008);

    // 4: lw Tnew=2 then two stall cycles
    set_e(32'h3010, 32'h8C08_0010, 32'h10, 32'h0, DM_W, 1'b0, 1'b1, 1'b1, 5'd8, 2'd2);
    tick();
    chk("lw_Tnew0", M_Tnew, 1);
    chk("lw_rw", M_RegWrite, 1);
    chk("lw_A3", M_A3, 8);
    chk("lw_DM_rd", M_DM_rd, 1);
    stall = 1'b1;
    set_e(32'h4000, 32'h0, 32'h20, 32'h0, DM_W, 1'b0, 1'b1, 1'b1, 5'd5, 2'd3);
    tick();
    chk("st1_Tnew", M_Tnew, 0);
    chk("st1_PC", M_PC, 32'h3010);
    chk("st1_A3", M_A3, 8);
    tick();
    chk("st2_Tnew", M_Tnew, 0);
    chk("st2_PC", M_PC, 32'h3010);
    chk("st2_A", M_A, 32'h10);

    // 5: flush beats stall
    flush = 1'b1;
    tick();
    chk("fl_valid", M_valid, 0);
    chk("fl_PC", M_PC, 32'h0);
    chk("fl_A3", M_A3, 0);
    stall = 1'b0; flush = 1'b0;

    // 6a: lb at odd address, in range
    set_e(32'h3020, 32'h8009_0003, 32'h3, 32'h0, DM_B, 1'b0, 1'b1, 1'b1, 5'd9, 2'd2);
    tick();
    chk("lb_adel", M_adel, 0);
    chk("lb_rw", M_RegWrite, 1);
    chk("lb_Tnew", M_Tnew, 1);

    // 6b: addu to $0 with an arbitrary ALU result
    set_e(32'h3024, 32'h0000_0021, 32'hFFFF_FFFF, 32'h0, DM_W, 1'b0, 1'b0, 1'b1, 5'd0, 2'd1);
    tick();
    chk("addu_rw", M_RegWrite, 0);
    chk("addu_fault", {M_adel, M_ades}, 0);
    chk("addu_A", M_A, 32'hFFFF_FFFF);

    // Non-memory ALU op with a real destination, Tnew=3 ages to 2
    set_e(32'h3028, 32'h0000_0021, 32'h8000_0001, 32'h0, DM_H, 1'b0, 1'b0, 1'b1, 5'd3, 2'd3);
    tick();
    chk("alu_rw", M_RegWrite, 1);
    chk("alu_A3", M_A3, 3);
    chk("alu_Tnew", M_Tnew, 2);
    chk("alu_fault", {M_adel, M_ades}, 0);

    // Illegal wr&rd: treated as a store
    set_e(32'h302C, 32'h0, 32'h108, 32'h55, DM_W, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0);
    tick();
    chk("both_wr", M_DM_wr, 1);
    chk("both_rd", M_DM_rd, 0);

    // Unknown size code on a load faults
    set_e(32'h3030, 32'h0, 32'h100, 32'h0, 3'd7, 1'b0, 1'b1, 1'b1, 5'd4, 2'd2);
    tick();
    chk("unk_adel", M_adel, 1);
    chk("unk_rw", M_RegWrite, 0);

    // Aligned halfword store and first out-of-range store address
    set_e(32'h3034, 32'h0, 32'hFFE, 32'h0, DM_H, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    tick();
    chk("sh_ok_wr", M_DM_wr, 1);
    set_e(32'h3038, 32'h0, 32'h1000, 32'h0, DM_B, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    tick();
    chk("sb_oor_ades", M_ades, 1);
    chk("sb_oor_wr", M_DM_wr, 0);

    // Reset mid-stream clears a valid instruction
    reset = 1'b1;
    tick();
    chk("rst2_valid", M_valid, 0);
    chk("rst2_A", M_A, 32'h0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
